param_shift_reg: RTL and testbench
==================================

PARAM_SHIFT_REG -- requirements
Module: param_shift_reg

Interface
REQ-001 Parameter WIDTH, default 1: bits per stage, SHALL be >= 1.
REQ-002 Parameter DEPTH, default 6: number of stages, SHALL be >= 2.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 clr  input  1  synchronous clear of all stages and fill count.
REQ-006 en  input  1  operation enable; when low, mode SHALL be ignored and state held.
REQ-007 mode  input  2  operation select: 00 HOLD, 01 SHIFT, 10 ROTATE, 11 LOAD.
REQ-008 din  input  WIDTH  serial data into stage 0.
REQ-009 load_data  input  DEPTH*WIDTH  parallel load word; stage i at bits [i*WIDTH +: WIDTH].
REQ-010 tap_sel  input  clog2(DEPTH)  stage index driven on tap_out.
REQ-011 q_all  output  DEPTH*WIDTH  all stages, same packing as load_data.
REQ-012 dout  output  WIDTH  stage DEPTH-1.
REQ-013 tap_out  output  WIDTH  stage[tap_sel], combinational.
REQ-014 fill_cnt  output  clog2(DEPTH+1)  number of valid stages.
REQ-015 full  output  1  high when fill_cnt == DEPTH.

Function
REQ-016 All stage updates SHALL be nonblocking-equivalent: every stage samples pre-edge values of its source in the same cycle.
REQ-017 Priority per edge SHALL be: clr, then en low (hold), then mode.
REQ-018 clr=1: all stages <= 0, fill_cnt <= 0, regardless of en and mode.
REQ-019 HOLD: stages and fill_cnt unchanged.
REQ-020 SHIFT: stage0 <= din, stage i <= stage i-1 for i=1..DEPTH-1; old stage DEPTH-1 discarded; fill_cnt <= min(fill_cnt+1, DEPTH).
REQ-021 ROTATE: stage0 <= stage DEPTH-1, stage i <= stage i-1; din ignored; fill_cnt unchanged.
REQ-022 LOAD: stage i <= load_data slice i for all i; fill_cnt <= DEPTH.
REQ-023 Latency: a value on din in an enabled SHIFT cycle SHALL appear on dout after exactly DEPTH enabled SHIFT edges, independent of intervening disabled cycles.
REQ-024 fill_cnt SHALL saturate at DEPTH; no wrap-around.
REQ-025 tap_sel >= DEPTH (non-power-of-two DEPTH) SHALL drive tap_out to all zeros.
REQ-026 q_all, dout, full SHALL be direct register-derived values with no combinational path from din, mode or en.

Reset
REQ-027 rst_n low SHALL immediately, without clock, force all stages to 0, fill_cnt to 0, full to 0; dout and q_all read 0.
REQ-028 rst_n assertion mid-operation (any mode) SHALL discard state; first rising edge after rst_n deassertion SHALL execute normally per REQ-017.

Structure
REQ-029 Mode encodings (HOLD, SHIFT, ROTATE, LOAD) and the width helper for fill_cnt SHALL live in shared package shift_pkg.
REQ-030 One sub-module shift_stage (WIDTH-bit register with async active-low reset, enable and 2:1 source select) SHALL be instantiated DEPTH times via generate; fill counter and tap mux in the top level.

Verification
REQ-031 WIDTH=1, DEPTH=6, SHIFT with din=1 for one edge then 0 -> q_all = 000001, 000010, ... 100000; dout=1 on the 6th edge; fill_cnt 1..6 then holds 6, full=1.
REQ-032 LOAD load_data=6'b100101, then 3 ROTATE edges -> q_all = 001011, 010110, 101100; fill_cnt=6 throughout.
REQ-033 SHIFT with en toggling 1,0,1,0,... -> stages advance only on en=1 edges; dout latency = 6 enabled edges.
REQ-034 clr=1 with en=0, mode=LOAD -> q_all=0, fill_cnt=0 next edge; clr wins.
REQ-035 Mid-SHIFT after 3 edges, assert rst_n low between edges -> q_all, fill_cnt 0 before next edge; release, SHIFT din=1 -> q_all=000001, fill_cnt=1.
REQ-036 WIDTH=8, DEPTH=5, LOAD stages 0x11..0x55, sweep tap_sel 0..7 -> tap_out 0x11,0x22,0x33,0x44,0x55,0x00,0x00,0x00.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the parameterised shift register.
//   mode_e     : operation select encoding driven on the mode port
//   cnt_width  : bit width needed to hold a fill count of 0..depth
package shift_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_SHIFT  = 2'b01,
    MODE_ROTATE = 2'b10,
    MODE_LOAD   = 2'b11
  } mode_e;

  // Fill count spans 0..depth inclusive, hence depth+1 codes.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One stage of the shift register: a WIDTH-bit register with a
// synchronous clear, an update enable and a 2:1 source select.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to zero (beats en)
//   en         : capture the selected source on this edge
//   sel        : 0 selects src_a (chain neighbour), 1 selects src_b (load)
//   q          : registered stage value
module shift_stage #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             sel,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= sel ? src_b : src_a;
    end
  end

endmodule

// File: rtl/param_shift_reg.sv
// Parameterised shift register with hold / shift / rotate / parallel load,
// a saturating fill counter and a combinational tap read port.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear of all stages and the fill count
//   en         : operation enable; low holds everything and ignores mode
//   mode       : 00 hold, 01 shift, 10 rotate, 11 load
//   din        : serial input into stage 0 (shift only)
//   load_data  : parallel load word, stage i at [i*WIDTH +: WIDTH]
//   tap_sel    : stage index shown on tap_out (out of range reads zero)
//   q_all      : all stages, same packing as load_data
//   dout       : last stage (DEPTH-1)
//   tap_out    : stage[tap_sel]
//   fill_cnt   : number of valid stages, saturates at DEPTH
//   full       : fill_cnt == DEPTH
module param_shift_reg
  import shift_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         en,
  input  logic [1:0]                   mode,
  input  logic [WIDTH-1:0]             din,
  input  logic [DEPTH*WIDTH-1:0]       load_data,
  input  logic [$clog2(DEPTH)-1:0]     tap_sel,
  output logic [DEPTH*WIDTH-1:0]       q_all,
  output logic [WIDTH-1:0]             dout,
  output logic [WIDTH-1:0]             tap_out,
  output logic [cnt_width(DEPTH)-1:0]  fill_cnt,
  output logic                         full
);

  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  mode_e            op;
  logic             step_en;
  logic             load_sel;
  logic [WIDTH-1:0] stage_q [DEPTH];

  assign op = mode_e'(mode);

  // Every non-hold mode updates all stages; only load picks the parallel
  // source, shift and rotate differ solely in what feeds stage 0.
  always_comb begin
    step_en  = en && (op != MODE_HOLD);
    load_sel = (op == MODE_LOAD);
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic [WIDTH-1:0] src_a;

    if (g == 0) begin : g_head
      assign src_a = (op == MODE_ROTATE) ? stage_q[DEPTH-1] : din;
    end else begin : g_body
      assign src_a = stage_q[g-1];
    end

    shift_stage #(.WIDTH(WIDTH)) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .en    (step_en),
      .sel   (load_sel),
      .src_a (src_a),
      .src_b (load_data[g*WIDTH +: WIDTH]),
      .q     (stage_q[g])
    );

    assign q_all[g*WIDTH +: WIDTH] = stage_q[g];
  end

  assign dout = stage_q[DEPTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_cnt <= '0;
    end else if (clr) begin
      fill_cnt <= '0;
    end else if (en) begin
      case (op)
        MODE_SHIFT: if (fill_cnt != DEPTH_C) fill_cnt <= fill_cnt + 1'b1;
        MODE_LOAD:  fill_cnt <= DEPTH_C;
        default:    fill_cnt <= fill_cnt;
      endcase
    end
  end

  assign full = (fill_cnt == DEPTH_C);

  // Indices past DEPTH-1 match no stage and fall through to zero.
  always_comb begin
    tap_out = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (int'(tap_sel) == i) tap_out = stage_q[i];
    end
  end

endmodule

// File: tb/tb_param_shift_reg.sv
module tb_param_shift_reg;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A: WIDTH=1, DEPTH=6 ----------------
  logic       clr6 = 0, en6 = 0, din6 = 0;
  logic [1:0] mode6 = 0;
  logic [5:0] ld6 = 0;
  logic [2:0] tap6 = 0;
  logic [5:0] q6;
  logic       dout6, tapo6, full6;
  logic [2:0] fill6;

  param_shift_reg #(.WIDTH(1), .DEPTH(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .clr(clr6), .en(en6), .mode(mode6),
    .din(din6), .load_data(ld6), .tap_sel(tap6), .q_all(q6),
    .dout(dout6), .tap_out(tapo6), .fill_cnt(fill6), .full(full6)
  );

  // ---------------- DUT B: WIDTH=8, DEPTH=5 ----------------
  logic        clr5 = 0, en5 = 0;
  logic [1:0]  mode5 = 0;
  logic [7:0]  din5 = 0;
  logic [39:0] ld5 = 0;
  logic [2:0]  tap5 = 0;
  logic [39:0] q5;
  logic [7:0]  dout5, tapo5;
  logic        full5;
  logic [2:0]  fill5;

  param_shift_reg #(.WIDTH(8), .DEPTH(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .clr(clr5), .en(en5), .mode(mode5),
    .din(din5), .load_data(ld5), .tap_sel(tap5), .q_all(q5),
    .dout(dout5), .tap_out(tapo5), .fill_cnt(fill5), .full(full5)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- vector table for DUT A ----------------
  typedef struct {
    logic       clr;
    logic       en;
    logic [1:0] mode;
    logic       din;
    logic [5:0] load;
    logic [5:0] exp_q;
    int         exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(logic c, logic e, logic [1:0] m, logic d,
                               logic [5:0] ld, logic [5:0] q, int n);
    vec_t v;
    v.clr = c; v.en = e; v.mode = m; v.din = d; v.load = ld;
    v.exp_q = q; v.exp_cnt = n;
    return v;
  endfunction

  localparam logic [1:0] HOLD = 2'b00, SHIFT = 2'b01, ROT = 2'b10, LOAD = 2'b11;

  // ---------------- reference model for DUT B ----------------
  logic [7:0] m5 [5];
  int         mc5;

  function automatic void model_reset();
    for (int i = 0; i < 5; i++) m5[i] = 8'h00;
    mc5 = 0;
  endfunction

  function automatic void model_step(logic c, logic e, logic [1:0] md,
                                     logic [7:0] d, logic [39:0] ld);
    logic [7:0] last;
    if (c) begin
      model_reset();
    end else if (e) begin
      case (md)
        SHIFT: begin
          for (int i = 4; i > 0; i--) m5[i] = m5[i-1];
          m5[0] = d;
          if (mc5 < 5) mc5 = mc5 + 1;
        end
        ROT: begin
          last = m5[4];
          for (int i = 4; i > 0; i--) m5[i] = m5[i-1];
          m5[0] = last;
        end
        LOAD: begin
          for (int i = 0; i < 5; i++) m5[i] = ld[i*8 +: 8];
          mc5 = 5;
        end
        default: ;
      endcase
    end
  endfunction

  function automatic logic [39:0] model_pack();
    logic [39:0] p;
    for (int i = 0; i < 5; i++) p[i*8 +: 8] = m5[i];
    return p;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    logic [5:0] eq;
    logic [7:0] et;

    // Shift a single one through, then let it drop out.
    vecs.push_back(mkv(0, 1, SHIFT, 1, 6'h00, 6'b000001, 1));
    vecs.push_back(mkv(0, 1, SHIFT, 0, 6'h00, 6'b000010, 2));
    vecs.push_back(mkv(0, 1, SHIFT, 0, 6'h00, 6'b000100, 3));
    vecs.push_back(mkv(0, 1, SHIFT, 0, 6'h00, 6'b001000, 4));
    vecs.push_back(mkv(0, 1, SHIFT, 0, 6'h00, 6'b010000, 5));
    vecs.push_back(mkv(0, 1, SHIFT, 0, 6'h00, 6'b100000, 6));
    vecs.push_back(mkv(0, 1, SHIFT, 0, 6'h00, 6'b000000, 6));
    // Load then rotate; din must be ignored during rotate.
    vecs.push_back(mkv(0, 1, LOAD,  0, 6'b100101, 6'b100101, 6));
    vecs.push_back(mkv(0, 1, ROT,   1, 6'h00, 6'b001011, 6));
    vecs.push_back(mkv(0, 1, ROT,   0, 6'h00, 6'b010110, 6));
    vecs.push_back(mkv(0, 1, ROT,   1, 6'h00, 6'b101100, 6));
    vecs.push_back(mkv(0, 1, HOLD,  1, 6'h3f, 6'b101100, 6));
    vecs.push_back(mkv(0, 0, LOAD,  1, 6'h3f, 6'b101100, 6));
    // Clear beats en=0 and a pending load.
    vecs.push_back(mkv(1, 0, LOAD,  1, 6'h3f, 6'b000000, 0));
    // Shift with en toggling: latency counts only enabled edges.
    vecs.push_back(mkv(0, 1, SHIFT, 1, 6'h00, 6'b000001, 1));
    vecs.push_back(mkv(0, 0, SHIFT, 1, 6'h00, 6'b000001, 1));
    vecs.push_back(mkv(0, 1, SHIFT, 0, 6'h00, 6'b000010, 2));
    vecs.push_back(mkv(0, 0, SHIFT, 1, 6'h00, 6'b000010, 2));
    vecs.push_back(mkv(0, 1, SHIFT, 0, 6'h00, 6'b000100, 3));
    vecs.push_back(mkv(0, 0, SHIFT, 1, 6'h00, 6'b000100, 3));
    vecs.push_back(mkv(0, 1, SHIFT, 0, 6'h00, 6'b001000, 4));
    vecs.push_back(mkv(0, 0, SHIFT, 1, 6'h00, 6'b001000, 4));
    vecs.push_back(mkv(0, 1, SHIFT, 0, 6'h00, 6'b010000, 5));
    vecs.push_back(mkv(0, 0, SHIFT, 1, 6'h00, 6'b010000, 5));
    vecs.push_back(mkv(0, 1, SHIFT, 0, 6'h00, 6'b100000, 6));

    // Reset state, checked while rst_n is still low.
    @(posedge clk); @(posedge clk); #1;
    check("rst_q6", q6, 0);
    check("rst_fill6", fill6, 0);
    check("rst_full6", full6, 0);
    check("rst_dout6", dout6, 0);
    check("rst_q5", q5, 0);
    check("rst_fill5", fill5, 0);
    rst_n = 1'b1;

    // Table-driven phase on DUT A.
    foreach (vecs[i]) begin
      clr6 = vecs[i].clr; en6 = vecs[i].en; mode6 = vecs[i].mode;
      din6 = vecs[i].din; ld6 = vecs[i].load;
      tap6 = 3'($urandom_range(0, 7));
      @(posedge clk); #1;
      eq = vecs[i].exp_q;
      check($sformatf("v%0d_q", i), q6, eq);
      check($sformatf("v%0d_fill", i), fill6, vecs[i].exp_cnt);
      check($sformatf("v%0d_full", i), full6, vecs[i].exp_cnt == 6);
      check($sformatf("v%0d_dout", i), dout6, eq[5]);
      check($sformatf("v%0d_tap", i), tapo6, (tap6 < 6) ? eq[tap6] : 1'b0);
    end

    // Asynchronous reset in the middle of shifting.
    clr6 = 1; en6 = 0; mode6 = HOLD;
    @(posedge clk); #1;
    clr6 = 0; en6 = 1; mode6 = SHIFT; din6 = 1;
    repeat (3) @(posedge clk);
    #1;
    check("mid_q_before_rst", q6, 6'b000111);
    check("mid_fill_before_rst", fill6, 3);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_q6", q6, 0);
    check("async_rst_fill6", fill6, 0);
    check("async_rst_full6", full6, 0);
    check("async_rst_dout6", dout6, 0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_q6", q6, 6'b000001);
    check("post_rst_fill6", fill6, 1);
    en6 = 0;

    // DUT B was also reset above: clean start for its model.
    model_reset();
    clr5 = 0; en5 = 1; mode5 = LOAD; ld5 = 40'h55_44_33_22_11;
    @(posedge clk); #1;
    en5 = 0;
    model_step(0, 1, LOAD, 8'h00, 40'h55_44_33_22_11);
    check("load5_q", q5, 40'h55_44_33_22_11);
    check("load5_fill", fill5, 5);
    check("load5_full", full5, 1);
    for (int t = 0; t < 8; t++) begin
      tap5 = 3'(t);
      #1;
      et = (t < 5) ? 8'(8'h11 * (t + 1)) : 8'h00;
      check($sformatf("tap5_sel%0d", t), tapo5, et);
    end

    // Randomised phase on DUT B against the reference model.
    for (int n = 0; n < 400; n++) begin
      clr5  = ($urandom_range(0, 31) == 0);
      en5   = ($urandom_range(0, 3) != 0);
      mode5 = 2'($urandom_range(0, 3));
      din5  = 8'($urandom);
      ld5   = {8'($urandom), 32'($urandom)};
      tap5  = 3'($urandom_range(0, 7));
      model_step(clr5, en5, mode5, din5, ld5);
      @(posedge clk); #1;
      check($sformatf("rnd%0d_q", n), q5, model_pack());
      check($sformatf("rnd%0d_fill", n), fill5, mc5);
      check($sformatf("rnd%0d_full", n), full5, mc5 == 5);
      check($sformatf("rnd%0d_dout", n), dout5, m5[4]);
      check($sformatf("rnd%0d_tap", n), tapo5, (tap5 < 5) ? m5[tap5] : 8'h00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
